// File: rtl/reset_pulse_gen_pkg.sv
// Shared types and defaults for the reset pulse generator.
`timescale 1ns/1ps
package reset_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  localparam int DROP_W           = 8;
  localparam int DEF_HOLD_W       = 8;
  localparam int DEF_DEFAULT_HOLD = 16;
  localparam int DEF_COOLDOWN     = 4;
  localparam int DEF_INIT_ASSERT  = 1;

endpackage

// File: rtl/reset_pulse_gen_cnt.sv
// Loadable down-counter with zero flag; stops at zero instead of wrapping.
`timescale 1ns/1ps
module reset_pulse_gen_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/reset_pulse_gen.sv
// Request-driven reset pulse generator with enforced cooldown and optional power-on pulse.
//   state       | meaning
//   ST_IDLE     | ready for a request (or waiting for the first edge after reset)
//   ST_ASSERT   | assert_out high, hold counter running
//   ST_COOLDOWN | assert_out low, cooldown counter running
`timescale 1ns/1ps
module reset_pulse_gen
  import reset_pulse_gen_pkg::*;
#(
  parameter int HOLD_W       = DEF_HOLD_W,
  parameter int DEFAULT_HOLD = DEF_DEFAULT_HOLD,
  parameter int COOLDOWN     = DEF_COOLDOWN,
  parameter int INIT_ASSERT  = DEF_INIT_ASSERT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [HOLD_W-1:0] hold_len,
  output logic              req_rdy,
  output logic              assert_out,
  output logic              busy,
  output logic              done,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [HOLD_W-1:0] DEF_L   = HOLD_W'(DEFAULT_HOLD);
  localparam logic [HOLD_W-1:0] CD_LOAD = (COOLDOWN > 0) ? HOLD_W'(COOLDOWN - 1) : '0;

  state_t            state, state_nxt;
  logic              init_pending;
  logic              assert_nxt, busy_nxt, done_nxt;
  logic              hold_load, hold_dec, hold_zero;
  logic              cd_load, cd_dec, cd_zero;
  logic [HOLD_W-1:0] hold_eff, hold_val;

  // init_pending stays set through reset so req_rdy reads 0 until the first edge.
  assign req_rdy  = (state == ST_IDLE) && !init_pending;
  assign hold_eff = (hold_len == '0) ? DEF_L : hold_len;
  assign hold_val = init_pending ? (DEF_L - 1'b1) : (hold_eff - 1'b1);

  always_comb begin
    state_nxt = state;
    hold_load = 1'b0;
    hold_dec  = 1'b0;
    cd_load   = 1'b0;
    cd_dec    = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (init_pending) begin
          if (INIT_ASSERT != 0) begin
            state_nxt = ST_ASSERT;
            hold_load = 1'b1;
          end
        end else if (req) begin
          state_nxt = ST_ASSERT;
          hold_load = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (hold_zero) begin
          if (COOLDOWN > 0) begin
            state_nxt = ST_COOLDOWN;
            cd_load   = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          hold_dec = 1'b1;
        end
      end
      ST_COOLDOWN: begin
        if (cd_zero) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          cd_dec = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    assert_nxt = (state_nxt == ST_ASSERT);
    busy_nxt   = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      init_pending <= 1'b1;
      assert_out   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      init_pending <= 1'b0;
      assert_out   <= assert_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      if (req && !req_rdy && !init_pending && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  reset_pulse_gen_cnt #(.W(HOLD_W)) u_hold_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hold_load),
    .load_val (hold_val),
    .dec      (hold_dec),
    .zero     (hold_zero)
  );

  reset_pulse_gen_cnt #(.W(HOLD_W)) u_cd_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cd_load),
    .load_val (CD_LOAD),
    .dec      (cd_dec),
    .zero     (cd_zero)
  );

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Bench for reset_pulse_gen: cycle-arithmetic reference model, vector table, corner sequences.
`timescale 1ns/1ps
module tb_reset_pulse_gen;

  localparam int DH = 16;
  localparam int C  = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, req;
  logic [7:0] hold_len;
  logic       req_rdy, assert_out, busy, done;
  logic [7:0] drop_cnt;

  logic       rst0_n, req0;
  logic [7:0] hold_len0;
  logic       req_rdy0, assert_out0, busy0, done0;
  logic [7:0] drop_cnt0;

  reset_pulse_gen dut (
    .clk(clk), .rst_n(rst_n), .req(req), .hold_len(hold_len),
    .req_rdy(req_rdy), .assert_out(assert_out), .busy(busy), .done(done),
    .drop_cnt(drop_cnt)
  );

  reset_pulse_gen #(.COOLDOWN(0), .INIT_ASSERT(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .req(req0), .hold_len(hold_len0),
    .req_rdy(req_rdy0), .assert_out(assert_out0), .busy(busy0), .done(done0),
    .drop_cnt(drop_cnt0)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: edge index of last accept (m_k) and its length (m_l).
  bit     m_rst, m_init;
  longint m_n, m_k, m_l;
  int     m_drop;

  function automatic bit m_live();
    return !m_rst && !m_init;
  endfunction
  function automatic bit m_rdy();
    return m_live() && (m_n >= m_k + m_l + C);
  endfunction
  function automatic bit m_a();
    return m_live() && (m_n >= m_k) && (m_n < m_k + m_l);
  endfunction
  function automatic bit m_busy();
    return m_live() && (m_n >= m_k) && (m_n < m_k + m_l + C);
  endfunction
  function automatic bit m_done();
    return m_live() && (m_n == m_k + m_l + C);
  endfunction

  function automatic void m_edge(input logic r, input logic [7:0] hl);
    bit rdy_prev;
    if (m_rst) return;
    rdy_prev = m_rdy();
    m_n++;
    if (m_init) begin
      m_init = 1'b0;
      m_k    = m_n;
      m_l    = DH;
    end else if (r) begin
      if (rdy_prev) begin
        m_k = m_n;
        m_l = (hl == 8'd0) ? DH : hl;
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("assert_out", {8'd0, assert_out}, {8'd0, m_a()});
    chk("busy",       {8'd0, busy},       {8'd0, m_busy()});
    chk("done",       {8'd0, done},       {8'd0, m_done()});
    chk("req_rdy",    {8'd0, req_rdy},    {8'd0, m_rdy()});
    chk("drop_cnt",   {1'b0, drop_cnt},   9'(m_drop));
  endtask

  task automatic cycle(input logic r, input logic [7:0] hl);
    req      = r;
    hold_len = hl;
    @(posedge clk);
    m_edge(r, hl);
    #1;
    check_model();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      if (req_rdy === 1'b1) break;
      cycle(1'b0, 8'd0);
    end
    chk("idle_reached", {8'd0, req_rdy}, 9'd1);
  endtask

  task automatic do_reset();
    #2;
    rst_n  = 1'b0;
    m_rst  = 1'b1;
    m_init = 1'b1;
    m_drop = 0;
    #1;
    chk("rst_async_assert", {8'd0, assert_out}, 9'd0);
    chk("rst_async_drop",   {1'b0, drop_cnt},   9'd0);
    check_model();
    cycle(1'b1, 8'd3);
    cycle(1'b0, 8'd0);
    #2;
    rst_n = 1'b1;
    m_rst = 1'b0;
  endtask

  task automatic pulse_len(input logic [7:0] hl, input int exp, input string nm);
    int len;
    len = 0;
    wait_idle();
    cycle(1'b1, hl);
    for (int i = 0; i < 400 && assert_out === 1'b1; i++) begin
      len++;
      cycle(1'b0, 8'd0);
    end
    chk(nm, 9'(len), 9'(exp));
  endtask

  task automatic step0(input logic r, input logic [7:0] hl);
    req0      = r;
    hold_len0 = hl;
    cycle(1'b0, 8'd0);
  endtask

  typedef struct {
    logic       r;
    logic [7:0] hl;
    logic       a, b, d, rdy;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ca, cb, cd, done_at, last, cyc;
    logic prev_a;

    // HOLD_LEN=3 from IDLE: pulse 3, cooldown 4, DONE after edge k+7.
    tbl[0] = '{1'b1, 8'd3,   1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd200, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'd9,   1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; req = 1'b0; hold_len = 8'd0;
    rst0_n = 1'b0; req0 = 1'b0; hold_len0 = 8'd0;
    m_rst = 1'b1; m_init = 1'b1; m_drop = 0; m_n = 0; m_k = 0; m_l = 0;

    for (int i = 0; i < 3; i++) cycle(1'b1, 8'd5);
    chk("rst_rdy", {8'd0, req_rdy}, 9'd0);
    #2;
    rst_n = 1'b1;
    m_rst = 1'b0;

    // Power-on pulse.
    ca = 0; cb = 0; cd = 0; done_at = -1;
    for (int i = 1; i <= 25; i++) begin
      cycle(1'b0, 8'd0);
      ca += int'(assert_out);
      cb += int'(busy);
      if (done === 1'b1) begin
        cd++;
        done_at = i;
      end
    end
    chk("por_high_cycles", 9'(ca), 9'd16);
    chk("por_busy_cycles", 9'(cb), 9'd20);
    chk("por_done_count",  9'(cd), 9'd1);
    chk("por_done_at",     9'(done_at), 9'd21);

    wait_idle();
    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].hl);
      chk($sformatf("tbl%0d_assert", i), {8'd0, assert_out}, {8'd0, tbl[i].a});
      chk($sformatf("tbl%0d_busy", i),   {8'd0, busy},       {8'd0, tbl[i].b});
      chk($sformatf("tbl%0d_done", i),   {8'd0, done},       {8'd0, tbl[i].d});
      chk($sformatf("tbl%0d_rdy", i),    {8'd0, req_rdy},    {8'd0, tbl[i].rdy});
    end

    pulse_len(8'd0,   16,  "len_default");
    pulse_len(8'd255, 255, "len_255");
    pulse_len(8'd1,   1,   "len_1");
    pulse_len(8'd7,   7,   "len_7");

    // Continuous request: rising edges of assert_out every L+C+1 = 7 cycles.
    wait_idle();
    prev_a = assert_out;
    last = -1;
    for (cyc = 0; cyc < 320; cyc++) begin
      cycle(1'b1, 8'd2);
      if (assert_out === 1'b1 && prev_a === 1'b0) begin
        if (last >= 0) chk("spacing", 9'(cyc - last), 9'd7);
        last = cyc;
      end
      prev_a = assert_out;
    end
    chk("drop_saturated", {1'b0, drop_cnt}, 9'd255);

    // Abort at cycle 5 of a 16-cycle pulse.
    wait_idle();
    cycle(1'b1, 8'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'd7);
    chk("abort_pre_high", {8'd0, assert_out}, 9'd1);
    do_reset();
    cycle(1'b1, 8'd5);
    chk("init_edge_no_drop", {1'b0, drop_cnt}, 9'd0);
    chk("init_edge_assert",  {8'd0, assert_out}, 9'd1);
    cd = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, 8'd0);
      cd += int'(done);
    end
    chk("abort_done_count", 9'(cd), 9'd1);

    // Randomized traffic against the model, with occasional async resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        logic       r;
        logic [7:0] hl;
        r  = ($urandom_range(0, 2) == 0);
        hl = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
        cycle(r, hl);
      end
    end

    // COOLDOWN=0, INIT_ASSERT=0 instance.
    chk("d0_rst_rdy",    {8'd0, req_rdy0},    9'd0);
    chk("d0_rst_assert", {8'd0, assert_out0}, 9'd0);
    #2;
    rst0_n = 1'b1;
    step0(1'b0, 8'd0);
    chk("d0_init_rdy",    {8'd0, req_rdy0},    9'd1);
    chk("d0_init_assert", {8'd0, assert_out0}, 9'd0);
    chk("d0_init_done",   {8'd0, done0},       9'd0);
    step0(1'b1, 8'd1);
    chk("d0_p1_assert", {8'd0, assert_out0}, 9'd1);
    chk("d0_p1_busy",   {8'd0, busy0},       9'd1);
    chk("d0_p1_rdy",    {8'd0, req_rdy0},    9'd0);
    step0(1'b1, 8'd1);
    chk("d0_p1_end",    {8'd0, assert_out0}, 9'd0);
    chk("d0_p1_done",   {8'd0, done0},       9'd1);
    chk("d0_p1_drop",   {1'b0, drop_cnt0},   9'd1);
    step0(1'b1, 8'd1);
    chk("d0_p2_assert", {8'd0, assert_out0}, 9'd1);
    chk("d0_p2_nodone", {8'd0, done0},       9'd0);
    step0(1'b0, 8'd0);
    chk("d0_p2_end",    {8'd0, assert_out0}, 9'd0);
    chk("d0_p2_done",   {8'd0, done0},       9'd1);
    step0(1'b0, 8'd0);
    chk("d0_idle_done", {8'd0, done0},       9'd0);
    chk("d0_idle_rdy",  {8'd0, req_rdy0},    9'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
